encoder_position: RTL



---
 rtl/encoder_position.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/encoder_position.sv
// -----------------------------------------------------------------------------
// encoder_position
//
// Downstream stage of the quadrature direction decoder in the robotic-arm
// joint path. Turns one-cycle cw/ccw step pulses into a signed joint
// position that is clamped to [POS_MIN, POS_MAX]. It also produces a windowed
// velocity estimate, which is the net accepted steps per WIN_CYCLES clocks.
//
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   cw        - one-cycle clockwise step pulse
//   ccw       - one-cycle counterclockwise step pulse
//   load      - preset strobe used for homing; takes priority over steps
//   load_val  - signed preset value, clamped into the legal range
//   pos       - signed current position (registered)
//   at_min    - pos == POS_MIN
//   at_max    - pos == POS_MAX
//   limit_hit - one-cycle pulse: a step was dropped at a limit
//   dir       - direction of the last accepted step (1 = cw)
//   vel       - signed net accepted steps in the last completed window
//   vel_valid - one-cycle pulse when vel updates
// -----------------------------------------------------------------------------
module encoder_position #(
  parameter int POS_W      = 16,
  parameter int POS_MIN    = -2000,
  parameter int POS_MAX    = 2000,
  parameter int WIN_CYCLES = 50000,
  parameter int VEL_W      = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cw,
  input  logic                    ccw,
  input  logic                    load,
  input  logic signed [POS_W-1:0] load_val,
  output logic signed [POS_W-1:0] pos,
  output logic                    at_min,
  output logic                    at_max,
  output logic                    limit_hit,
  output logic                    dir,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid
);

  localparam logic signed [POS_W-1:0] P_MIN   = POS_W'(POS_MIN);
  localparam logic signed [POS_W-1:0] P_MAX   = POS_W'(POS_MAX);
  localparam logic signed [POS_W-1:0] P_ONE   = POS_W'(1);
  localparam int                      CNT_W   = $clog2(WIN_CYCLES);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic signed [VEL_W-1:0] V_MAX   = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] V_MIN   = {1'b1, {(VEL_W-1){1'b0}}};
  localparam logic signed [VEL_W-1:0] V_ONE   = VEL_W'(1);

  // Add one accepted step to the accumulator without wrapping. The value
  // sticks at the end of the signed VEL_W range.
  function automatic logic signed [VEL_W-1:0] sat_step(
    input logic signed [VEL_W-1:0] a,
    input logic                    up,
    input logic                    dn
  );
    logic signed [VEL_W-1:0] r;
    r = a;
    if (up && (a != V_MAX)) r = a + V_ONE;
    if (dn && (a != V_MIN)) r = a - V_ONE;
    return r;
  endfunction

  logic                    step_up;
  logic                    step_dn;
  logic signed [POS_W-1:0] load_clamped;
  logic signed [POS_W-1:0] pos_nxt;
  logic                    dir_nxt;
  logic                    hit_nxt;
  logic                    acc_up;
  logic                    acc_dn;
  logic [CNT_W-1:0]        win_cnt;
  logic signed [VEL_W-1:0] acc;
  logic signed [VEL_W-1:0] acc_sum;

  // If cw and ccw arrive together, the pair cancels. Neither pulse is counted.
  assign step_up = cw & ~ccw;
  assign step_dn = ccw & ~cw;

  always_comb begin
    if (load_val < P_MIN)      load_clamped = P_MIN;
    else if (load_val > P_MAX) load_clamped = P_MAX;
    else                       load_clamped = load_val;
  end

  // Choose the next position. Load takes priority and discards any step in
  // the same cycle.
  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path leaves one unassigned and no latch is inferred.
    pos_nxt = pos;
    dir_nxt = dir;
    hit_nxt = 1'b0;
    acc_up  = 1'b0;
    acc_dn  = 1'b0;
    if (load) begin
      pos_nxt = load_clamped;
    end else if (step_up) begin
      if (pos < P_MAX) begin
        pos_nxt = pos + P_ONE;
        dir_nxt = 1'b1;
        acc_up  = 1'b1;
      end else begin
        hit_nxt = 1'b1;
      end
    end else if (step_dn) begin
      if (pos > P_MIN) begin
        pos_nxt = pos - P_ONE;
        dir_nxt = 1'b0;
        acc_dn  = 1'b1;
      end else begin
        hit_nxt = 1'b1;
      end
    end
  end

  assign acc_sum = sat_step(acc, acc_up, acc_dn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos       <= '0;
      dir       <= 1'b0;
      limit_hit <= 1'b0;
      win_cnt   <= '0;
      acc       <= '0;
      vel       <= '0;
      vel_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all state update together from the old values, so the order of statements here does not matter.
      pos       <= pos_nxt;
      dir       <= dir_nxt;
      limit_hit <= hit_nxt;
      // The window counter runs freely and is not affected by load. A step
      // accepted on the last cycle of a window is counted in that window.
      if (win_cnt == CNT_LAST) begin
        win_cnt   <= '0;
        vel       <= acc_sum;
        vel_valid <= 1'b1;
        acc       <= '0;
      end else begin
        win_cnt   <= win_cnt + CNT_ONE;
        vel_valid <= 1'b0;
        acc       <= acc_sum;
      end
    end
  end

  assign at_min = (pos == P_MIN);
  assign at_max = (pos == P_MAX);

endmodule
